hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 55 +++++
 tb/tb_hazard_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit: RF port arbitration, RAW stall, branch flush, stall watchdog
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_ra_i,
  input  logic [4:0]  id_rb_i,
  input  logic        id_ra_use_i,
  input  logic        id_rb_use_i,
  input  logic [4:0]  ex_rw_i,
  input  logic [1:0]  ex_rw_src_i,
  input  logic [4:0]  wb_rw_i,
  input  logic [1:0]  wb_rw_src_i,
  input  logic        br_taken_i,
  output logic [5:0]  stall_o,
  output logic        bubble_o,
  output logic        flush_o,
  output logic [4:0]  rf_addra_o,
  output logic        rf_wea_o,
  output logic [1:0]  hz_state_o,
  output logic [15:0] stall_cnt_o,
  output logic        err_o
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  state_t state;
  logic [2:0] cons_cnt;
  logic wb_wr, conflict, raw, br, hold;
  always_comb begin
    wb_wr = wb_rw_src_i != 2'd0;
    conflict = wb_wr & id_valid_i & id_ra_use_i;
    raw = id_valid_i & (ex_rw_src_i != 2'd0) & (ex_rw_i != 5'd0) &
          ((id_ra_use_i & (id_ra_i == ex_rw_i)) | (id_rb_use_i & (id_rb_i == ex_rw_i)));
    br = br_taken_i | (state == FLUSH);
    hold = conflict | raw;
    rf_wea_o = ~rst & wb_wr;
    rf_addra_o = rst ? 5'd0 : wb_wr ? wb_rw_i : id_ra_i;
    stall_o = rst ? 6'b111111 : br ? 6'b000000 : hold ? 6'b000111 : 6'b000000;
    bubble_o = rst | br | hold;
    flush_o = ~rst & br;
    hz_state_o = state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      stall_cnt_o <= 16'd0;
      cons_cnt <= 3'd0;
      err_o <= 1'b0;
    end else begin
      state <= br_taken_i ? FLUSH : (state != FLUSH && hold) ? STALL : RUN;
      if (stall_o != 6'd0 && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
      cons_cnt <= (stall_o == 6'd0) ? 3'd0 : (cons_cnt == 3'd4) ? 3'd4 : cons_cnt + 3'd1;
      err_o <= err_o | ((stall_o != 6'd0) & (cons_cnt >= 3'd3));
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic id_valid_i, id_ra_use_i, id_rb_use_i, br_taken_i;
  logic [4:0] id_ra_i, id_rb_i, ex_rw_i, wb_rw_i;
  logic [1:0] ex_rw_src_i, wb_rw_src_i;
  logic [5:0] stall_o;
  logic bubble_o, flush_o, rf_wea_o, err_o;
  logic [4:0] rf_addra_o;
  logic [1:0] hz_state_o;
  logic [15:0] stall_cnt_o;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ra_i(id_ra_i), .id_rb_i(id_rb_i),
    .id_ra_use_i(id_ra_use_i), .id_rb_use_i(id_rb_use_i), .ex_rw_i(ex_rw_i),
    .ex_rw_src_i(ex_rw_src_i), .wb_rw_i(wb_rw_i), .wb_rw_src_i(wb_rw_src_i),
    .br_taken_i(br_taken_i), .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .rf_addra_o(rf_addra_o), .rf_wea_o(rf_wea_o), .hz_state_o(hz_state_o),
    .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    id_valid_i = 0; id_ra_use_i = 0; id_rb_use_i = 0; br_taken_i = 0;
    id_ra_i = 0; id_rb_i = 0; ex_rw_i = 0; wb_rw_i = 0; ex_rw_src_i = 0; wb_rw_src_i = 0;
  endtask
  task automatic do_reset();
    rst = 1; clr();
    tick();
    rst = 0;
    #1;
  endtask
  initial begin
    rst = 1; clr();
    wb_rw_src_i = 1; wb_rw_i = 5;
    #1;
    chk("rst_stall", stall_o, 6'h3f);
    chk("rst_bubble", bubble_o, 1);
    chk("rst_flush", flush_o, 0);
    chk("rst_wea", rf_wea_o, 0);
    chk("rst_addra", rf_addra_o, 0);
    tick();
    chk("rst_state", hz_state_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    chk("rst_err", err_o, 0);
    rst = 0; clr();
    #1;
    chk("idle_stall", stall_o, 0);
    chk("idle_bubble", bubble_o, 0);
    wb_rw_src_i = 1; wb_rw_i = 5; id_valid_i = 1; id_ra_use_i = 1; id_ra_i = 3;
    #1;
    chk("pc_addra", rf_addra_o, 5);
    chk("pc_wea", rf_wea_o, 1);
    chk("pc_stall", stall_o, 6'h07);
    chk("pc_bubble", bubble_o, 1);
    tick();
    wb_rw_src_i = 0;
    #1;
    chk("pc2_addra", rf_addra_o, 3);
    chk("pc2_wea", rf_wea_o, 0);
    chk("pc2_stall", stall_o, 0);
    chk("pc2_state", hz_state_o, 1);
    tick();
    chk("pc3_state", hz_state_o, 0);
    chk("pc3_cnt", stall_cnt_o, 1);
    do_reset();
    id_valid_i = 1; id_rb_use_i = 1; id_rb_i = 7; ex_rw_i = 7; ex_rw_src_i = 2;
    #1;
    chk("lu1_stall", stall_o, 6'h07);
    tick();
    chk("lu2_stall", stall_o, 6'h07);
    chk("lu2_state", hz_state_o, 1);
    tick();
    chk("lu_cnt", stall_cnt_o, 2);
    ex_rw_src_i = 0;
    #1;
    chk("lu3_stall", stall_o, 0);
    do_reset();
    id_valid_i = 1; id_ra_use_i = 1; id_ra_i = 0; ex_rw_i = 0; ex_rw_src_i = 1;
    #1;
    chk("r0_stall", stall_o, 0);
    chk("r0_bubble", bubble_o, 0);
    id_ra_i = 4; ex_rw_i = 4; br_taken_i = 1;
    #1;
    chk("br1_flush", flush_o, 1);
    chk("br1_stall", stall_o, 0);
    chk("br1_bubble", bubble_o, 1);
    tick();
    br_taken_i = 0;
    #1;
    chk("br2_state", hz_state_o, 2);
    chk("br2_flush", flush_o, 1);
    chk("br2_stall", stall_o, 0);
    tick();
    chk("br3_state", hz_state_o, 0);
    chk("br3_flush", flush_o, 0);
    chk("br3_raw", stall_o, 6'h07);
    clr();
    tick();
    br_taken_i = 1;
    tick();
    tick();
    br_taken_i = 0;
    #1;
    chk("brr_state", hz_state_o, 2);
    chk("brr_flush", flush_o, 1);
    tick();
    chk("brr_run", hz_state_o, 0);
    chk("brr_noflush", flush_o, 0);
    do_reset();
    id_valid_i = 1; id_ra_use_i = 1; id_ra_i = 9; ex_rw_i = 9; ex_rw_src_i = 1;
    tick(); tick(); tick();
    chk("wd3_err", err_o, 0);
    tick();
    chk("wd4_err", err_o, 1);
    chk("wd4_cnt", stall_cnt_o, 4);
    clr();
    tick();
    chk("wd_sticky", err_o, 1);
    do_reset();
    chk("wd_rst_err", err_o, 0);
    chk("wd_rst_cnt", stall_cnt_o, 0);
    br_taken_i = 1;
    tick();
    br_taken_i = 0; rst = 1;
    #1;
    chk("rf_flush", flush_o, 0);
    tick();
    rst = 0;
    #1;
    chk("rf_state", hz_state_o, 0);
    chk("rf_noflush", flush_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
